// File: rtl/sort_pkg.sv
// Shared types and default sizing for the bubble-sort memory controller.
package sort_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        CMP,
        WR0,
        WR1,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/sort_ctrl_counter.sv
// Loadable up-counter: synchronous reset, load has priority over increment.
module sort_ctrl_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Count register: reset, then load, then increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sort_ctrl.sv
// In-place ascending bubble sort over a single-port memory of N words.
// Optional feature: define SORT_EARLY_EXIT_EN to finish after the first
// pass that performs no swap.
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int W  = DEF_W,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_rdata,
    output logic [W-1:0]  mem_wdata,
    output logic          mem_we
);

    localparam logic [AW-1:0] LAST = AW'(N - 2);

    state_t        state, state_n;
    logic [W-1:0]  a, b;
    logic [AW-1:0] i_q, j_q, last_j;
    logic          i_ld, i_en, j_ld, j_en;

    assign last_j = LAST - i_q;

    sort_ctrl_counter #(.WIDTH(AW)) u_i (
        .clk (clk),
        .rst (rst),
        .ld  (i_ld),
        .en  (i_en),
        .d   ('0),
        .q   (i_q)
    );

    sort_ctrl_counter #(.WIDTH(AW)) u_j (
        .clk (clk),
        .rst (rst),
        .ld  (j_ld),
        .en  (j_en),
        .d   ('0),
        .q   (j_q)
    );

`ifdef SORT_EARLY_EXIT_EN
    logic swapped, sw_clr, sw_set;

    // Tracks whether the current pass has exchanged any pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            swapped <= 1'b0;
        end else if (sw_clr) begin
            swapped <= 1'b0;
        end else if (sw_set) begin
            swapped <= 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Operand latches: A[j] arrives in RD1, A[j+1] arrives in CMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            a <= '0;
            b <= '0;
        end else begin
            if (state == RD1) begin
                a <= mem_rdata;
            end
            if (state == CMP) begin
                b <= mem_rdata;
            end
        end
    end

    // Next-state, memory strobes and counter controls.
    always_comb begin
        state_n   = state;
        busy      = 1'b1;
        done      = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        i_ld      = 1'b0;
        i_en      = 1'b0;
        j_ld      = 1'b0;
        j_en      = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        sw_clr    = 1'b0;
        sw_set    = 1'b0;
`endif
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    i_ld    = 1'b1;
                    j_ld    = 1'b1;
`ifdef SORT_EARLY_EXIT_EN
                    sw_clr  = 1'b1;
`endif
                    state_n = RD0;
                end
            end
            RD0: begin
                mem_addr = j_q;
                state_n  = RD1;
            end
            RD1: begin
                mem_addr = j_q + AW'(1);
                state_n  = CMP;
            end
            CMP: begin
                // b is still being latched, so compare against the live read data.
                if (a > mem_rdata) begin
                    state_n = WR0;
                end else begin
                    state_n = NEXT;
                end
            end
            WR0: begin
                mem_addr  = j_q;
                mem_wdata = b;
                mem_we    = 1'b1;
                state_n   = WR1;
            end
            WR1: begin
                mem_addr  = j_q + AW'(1);
                mem_wdata = a;
                mem_we    = 1'b1;
`ifdef SORT_EARLY_EXIT_EN
                sw_set    = 1'b1;
`endif
                state_n   = NEXT;
            end
            NEXT: begin
                if (j_q != last_j) begin
                    j_en    = 1'b1;
                    state_n = RD0;
                end else if (i_q == LAST) begin
                    state_n = DONE;
`ifdef SORT_EARLY_EXIT_EN
                end else if (!swapped) begin
                    state_n = DONE;
`endif
                end else begin
                    j_ld    = 1'b1;
                    i_en    = 1'b1;
`ifdef SORT_EARLY_EXIT_EN
                    sw_clr  = 1'b1;
`endif
                    state_n = RD0;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/sort_ctrl.md
SORT_CTRL -- requirements
Module: sort_ctrl

Interface
REQ-001 Parameters SHALL be: N, 8, element count (N >= 2); W, 8, element data width; AW, $clog2(N), address width.
REQ-002 clk  input  1  clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 start  input  1  request to sort memory words 0..N-1; sampled only in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 done  output  1  high for exactly one cycle, in DONE.
REQ-007 mem_addr  output  AW  single-port memory address.
REQ-008 mem_rdata  input  W  read data, valid one cycle after mem_addr is presented.
REQ-009 mem_wdata  output  W  write data.
REQ-010 mem_we  output  1  write strobe; memory writes mem_wdata at mem_addr on the same edge.

Function
REQ-011 Algorithm SHALL be bubble sort, ascending, unsigned compare, in place; pass counter i runs 0..N-2 and index counter j runs 0..N-2-i.
REQ-012 States SHALL be IDLE, RD0, RD1, CMP, WR0, WR1, NEXT, DONE.
REQ-013 IDLE: start=1 -> clear i, j and swapped -> RD0; start=0 -> stay in IDLE.
REQ-014 RD0: mem_addr=j -> RD1.
REQ-015 RD1: mem_addr=j+1; latch a<=mem_rdata (A[j]) -> CMP.
REQ-016 CMP: latch b<=mem_rdata (A[j+1]); a>b -> WR0; otherwise -> NEXT. Equal values SHALL NOT swap (stable).
REQ-017 WR0: mem_addr=j, mem_wdata=b, mem_we=1 -> WR1.
REQ-018 WR1: mem_addr=j+1, mem_wdata=a, mem_we=1; set swapped -> NEXT.
REQ-019 NEXT, j<N-2-i: j<=j+1 -> RD0.
REQ-020 NEXT, j==N-2-i and i==N-2: -> DONE.
REQ-021 NEXT, j==N-2-i otherwise: j<=0; i<=i+1; clear swapped -> RD0.
REQ-022 DONE: done=1 -> IDLE.
REQ-023 mem_we SHALL be 0 outside WR0/WR1; mem_addr and mem_wdata SHALL be 0 in IDLE and DONE.
REQ-024 start while busy SHALL be ignored and not queued.
REQ-025 Busy duration SHALL be exactly 4*compares + 2*swaps + 1 cycles.

Reset
REQ-026 rst SHALL force IDLE and set busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, i=j=0, swapped=0; rst has priority over start.
REQ-027 Reset mid-sort SHALL abort immediately without completing a pending swap; memory contents are then undefined-order but unmodified beyond writes already issued.

Configuration
REQ-028 SORT_EARLY_EXIT_EN defined: at NEXT with j==N-2-i and swapped==0, the controller SHALL go to DONE regardless of i.
REQ-029 SORT_EARLY_EXIT_EN undefined: all N-1 passes SHALL always execute; swapped SHALL have no effect on control.

Structure
REQ-030 Package sort_pkg SHALL hold the state enum typedef and default N/W constants.
REQ-031 i and j SHALL each be an instance of the team's counter block (rst/ld/en/d, width AW), with ld for clear and en for increment; all other logic stays in sort_ctrl.

Verification
REQ-032 N=4, memory [3,1,2,0], macro off -> final [0,1,2,3]; 6 compares, 5 swaps; busy for 35 cycles; done for one cycle.
REQ-033 N=4, memory [0,1,2,3], macro on -> done after one pass; busy for 13 cycles; no mem_we.
REQ-034 Same data as REQ-033, macro off -> busy for 25 cycles; no mem_we.
REQ-035 N=4, memory [5,5,5,5] -> no mem_we; contents unchanged.
REQ-036 N=2, memory [9,4] -> WR0 writes 4 to addr 0, WR1 writes 9 to addr 1; busy for 7 cycles.
REQ-037 rst asserted in WR0, then start asserted during busy -> IDLE the next cycle with mem_we=0 and busy=0; the start pulse issued during busy produces no sort.
